conv1_window_sequencer: RTL and testbench

CONV1_WINDOW_SEQUENCER -- requirements
Module: conv1_window_sequencer

---
 rtl/conv1_window_sequencer.sv | 142 ++++++++++++++
 tb/tb_conv1_window_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_window_sequencer.sv
// conv1 window sequencer: accepts a raster pixel stream and announces each complete KxK window.
// Optional: define CONV1_SEQ_WINCOUNT_EN to build the saturating per-frame window counter.
module conv1_window_sequencer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       win_valid,
  input  logic       win_ready,
  output logic [4:0] out_row,
  output logic [4:0] out_col,
  output logic       busy,
  output logic       done,
  output logic [9:0] win_count
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K    = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept;
  logic win_hit;
  logic last_pix;

  // A pixel may only enter when the window slot is free or being emptied this cycle.
  assign pix_ready = (state == RUN) && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign win_hit   = accept && (row >= ROW_K) && (col >= COL_K);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (abort) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && last_pix) state <= FLUSH;
        end
        FLUSH: begin
          if (!win_valid || win_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          row   <= '0;
          col   <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A new window in the same cycle as a handoff keeps valid high for back-to-back output.
      if (win_hit) begin
        win_valid <= 1'b1;
        out_row   <= 5'(row - ROW_K);
        out_col   <= 5'(col - COL_K);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef CONV1_SEQ_WINCOUNT_EN
  logic [9:0] win_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count_reg <= '0;
    end else if (abort) begin
      win_count_reg <= '0;
    end else if ((state == IDLE) && start) begin
      win_count_reg <= '0;
    end else if (win_valid && win_ready && (win_count_reg != 10'h3FF)) begin
      win_count_reg <= win_count_reg + 1'b1;
    end
  end

  assign win_count = win_count_reg;
`else
  assign win_count = '0;
`endif

endmodule

// File: tb/tb_conv1_window_sequencer.sv
// Scoreboard bench for conv1_window_sequencer: raster model pushes expected windows, monitor pops on handoff.
module tb_conv1_window_sequencer;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);
`ifdef CONV1_SEQ_WINCOUNT_EN
  localparam int EXP_WC = NWIN;
`else
  localparam int EXP_WC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic       pix_ready;
  logic       win_valid;
  logic [4:0] out_row;
  logic [4:0] out_col;
  logic       busy;
  logic       done;
  logic [9:0] win_count;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] c;
  } win_t;

  win_t exp_q[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   pv_mode = 0;
  int   wr_mode = 0;
  int   acc_cnt = 0;
  int   win_seen = 0;
  int   done_seen = 0;
  int   cyc = 0;
  int   acc116_cyc = -1;
  int   first_win_cyc = -1;

  conv1_window_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done),
    .win_count (win_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    check_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Input driver: modes 0=low, 1=high, 2=random 50%, 3=ready except for the final window.
  initial forever begin
    @(posedge clk);
    #1;
    case (pv_mode)
      0:       pix_valid = 1'b0;
      1:       pix_valid = 1'b1;
      default: pix_valid = 1'($urandom_range(0, 1));
    endcase
    case (wr_mode)
      0:       win_ready = 1'b0;
      1:       win_ready = 1'b1;
      2:       win_ready = 1'($urandom_range(0, 1));
      default: win_ready = !(win_valid && out_row == 5'd23 && out_col == 5'd23);
    endcase
  end

  // Raster model: each accepted pixel that completes a window queues its expected coordinates.
  initial forever begin
    @(negedge clk);
    if (rst_n && pix_valid && pix_ready) begin
      int r;
      int c;
      win_t e;
      r = acc_cnt / IMG_W;
      c = acc_cnt % IMG_W;
      if (acc_cnt == 116) acc116_cyc = cyc;
      if (r >= K - 1 && c >= K - 1) begin
        e.r = 5'(r - (K - 1));
        e.c = 5'(c - (K - 1));
        exp_q.push_back(e);
      end
      acc_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_seen++;
  end

  // Monitor: compares handoffs against the queue and checks stall behaviour.
  initial begin
    win_t held;
    logic stall_prev;
    win_t e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n && win_valid && first_win_cyc < 0) first_win_cyc = cyc;
      if (stall_prev && rst_n)
        check("stall_hold", int'({win_valid, out_row, out_col}), int'({1'b1, held}));
      if (rst_n && win_valid && !win_ready) begin
        check("stall_pix_ready", int'(pix_ready), 0);
        held = {out_row, out_col};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (rst_n && win_valid && win_ready) begin
        win_seen++;
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL win_unexpected: got window (%0d,%0d), expected none", out_row, out_col);
        end else begin
          e = exp_q.pop_front();
          check("win_row", int'(out_row), int'(e.r));
          check("win_col", int'(out_col), int'(e.c));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    exp_q.delete();
    acc_cnt = 0;
    win_seen = 0;
    done_seen = 0;
    acc116_cyc = -1;
    first_win_cyc = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen_in_time"}, int'(n < 20000), 1);
  endtask

  task automatic frame_end_checks(input string name);
    @(negedge clk);
    #1;
    check({name, "_windows"}, win_seen, NWIN);
    check({name, "_pixels"}, acc_cnt, NPIX);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_done_pulses"}, done_seen, 1);
    check({name, "_done_low_after"}, int'(done), 0);
    check({name, "_busy_low_after"}, int'(busy), 0);
    check({name, "_first_win_latency"}, first_win_cyc - acc116_cyc, 1);
    check({name, "_win_count"}, int'(win_count), EXP_WC);
  endtask

  task automatic run_frame(input string name, input int pv, input int wr);
    reset_model();
    pv_mode = pv;
    wr_mode = wr;
    pulse_start();
    wait_done(name);
    frame_end_checks(name);
    pv_mode = 0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({pix_ready, win_valid, out_row, out_col, busy, done, win_count}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_pix_ready", int'(pix_ready), 0);

    // Full frame, everything held ready
    run_frame("full", 1, 1);

    // Downstream stall after the first window, with a start issued mid-frame
    reset_model();
    pv_mode = 1;
    wr_mode = 0;
    pulse_start();
    n = 0;
    while (!win_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stall_first_window_in_time", int'(n < 2000), 1);
    repeat (10) @(negedge clk);
    check("stall_pix_count", acc_cnt, 117);
    check("stall_coords", int'({out_row, out_col}), 0);
    pulse_start();
    check("start_in_run_busy", int'(busy), 1);
    wr_mode = 1;
    repeat (60) @(posedge clk);
    pulse_start();
    check("start_in_run_busy2", int'(busy), 1);
    wait_done("stall");
    frame_end_checks("stall");
    pv_mode = 0;

    // Abort at pixel 300
    reset_model();
    pv_mode = 1;
    wr_mode = 1;
    pulse_start();
    n = 0;
    while (acc_cnt < 300 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reach_300", int'(n < 2000), 1);
    pv_mode = 0;
    pix_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_win_valid", int'(win_valid), 0);
    check("abort_win_count", int'(win_count), 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_seen, 0);
    check("abort_pix_ready", int'(pix_ready), 0);
    run_frame("after_abort", 1, 1);

    // Random handshakes on both sides
    run_frame("random", 2, 2);

    // Reset pulled low while the last window waits in FLUSH
    reset_model();
    pv_mode = 1;
    wr_mode = 3;
    pulse_start();
    n = 0;
    while (!(busy && win_valid && out_row == 5'd23 && out_col == 5'd23) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("flush_reached_in_time", int'(n < 5000), 1);
    repeat (3) @(negedge clk);
    check("flush_busy", int'(busy), 1);
    check("flush_win_valid", int'(win_valid), 1);
    check("flush_pix_ready", int'(pix_ready), 0);
    check("flush_pixels", acc_cnt, NPIX);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({pix_ready, win_valid, out_row, out_col, busy, done, win_count}), 0);
    check("flush_no_done", done_seen, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    acc_cnt = 0;
    pv_mode = 1;
    wr_mode = 1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_pix_ready", int'(pix_ready), 0);
    check("post_reset_pixels", acc_cnt, 0);
    pv_mode = 0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
